// File: rtl/pke_ram_core_if.sv
// pke_ram_core_if: engine port 0/1 and host side-port bus of the PKE working RAM.
interface pke_ram_core_if;
  logic PkeRamRd0, PkeRamWr0, PkeRamRd1, PkeRamWr1;
  logic [8:0] PkeRamAddr0, PkeRamAddr1;
  logic [63:0] PkeRamDat0, PkeRamDat1, PkeRamQ0, PkeRamQ1;
  logic HostReq, HostWr, HostAck, HostErr, CollErr, ParityErr;
  logic [9:0] HostAddr;
  logic [31:0] HostWdat, HostRdat;
  modport master (
    output PkeRamRd0, PkeRamWr0, PkeRamAddr0, PkeRamDat0,
    output PkeRamRd1, PkeRamWr1, PkeRamAddr1, PkeRamDat1,
    output HostReq, HostWr, HostAddr, HostWdat,
    input PkeRamQ0, PkeRamQ1, HostRdat, HostAck, HostErr, CollErr, ParityErr
  );
  modport slave (
    input PkeRamRd0, PkeRamWr0, PkeRamAddr0, PkeRamDat0,
    input PkeRamRd1, PkeRamWr1, PkeRamAddr1, PkeRamDat1,
    input HostReq, HostWr, HostAddr, HostWdat,
    output PkeRamQ0, PkeRamQ1, HostRdat, HostAck, HostErr, CollErr, ParityErr
  );
endinterface

// File: rtl/pke_ram_core.sv
// pke_ram_core: dual-port 64-bit PKE working RAM with a 32-bit host side-port on idle port 0 cycles.
// Optional PKE_RAM_PARITY_EN stores and checks one even-parity bit per 32-bit half.
module pke_ram_core #(
  parameter int DEPTH = 512,
  parameter int HOST_TMO = 64
) (
  input logic Clk,
  input logic Resetn,
  pke_ram_core_if.slave bus
);
  localparam int CW = $clog2(HOST_TMO);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} hostState_t;
  hostState_t state;
  logic [CW-1:0] waitCnt;
  logic hWr;
  logic [9:0] hAddr;
  logic [31:0] hWdat;
  logic [63:0] mem [DEPTH];
  logic rd0, wr0, rd1, wr1, hostGo, hostOk;
  logic [8:0] hWord;
  logic [63:0] hostWord;
  logic [31:0] hostHalf;

  function automatic logic inRange(input logic [8:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  assign rd0 = bus.PkeRamRd0 && inRange(bus.PkeRamAddr0);
  assign wr0 = bus.PkeRamWr0 && inRange(bus.PkeRamAddr0);
  assign rd1 = bus.PkeRamRd1 && inRange(bus.PkeRamAddr1);
  assign wr1 = bus.PkeRamWr1 && inRange(bus.PkeRamAddr1);
  assign hWord = hAddr[9:1];
  assign hostOk = inRange(hWord);
  assign hostGo = state == WAIT && !bus.PkeRamRd0 && !bus.PkeRamWr0;
  assign hostWord = hostOk ? mem[hWord] : '0;
  assign hostHalf = hAddr[0] ? hostWord[63:32] : hostWord[31:0];

  // Later assignments win: port 0 over port 1, host half over port 1's same half
  always_ff @(posedge Clk) begin
    if (wr1) mem[bus.PkeRamAddr1] <= bus.PkeRamDat1;
    if (wr0) mem[bus.PkeRamAddr0] <= bus.PkeRamDat0;
    if (hostGo && hWr && hostOk) mem[hWord][{hAddr[0], 5'd0} +: 32] <= hWdat;
  end

  always_ff @(posedge Clk or negedge Resetn)
    if (!Resetn) begin
      bus.PkeRamQ0 <= '0;
      bus.PkeRamQ1 <= '0;
      bus.CollErr <= 1'b0;
    end else begin
      if (bus.PkeRamRd0) bus.PkeRamQ0 <= rd0 ? mem[bus.PkeRamAddr0] : '0;
      if (bus.PkeRamRd1) bus.PkeRamQ1 <= rd1 ? mem[bus.PkeRamAddr1] : '0;
      if (wr0 && wr1 && bus.PkeRamAddr0 == bus.PkeRamAddr1 && bus.PkeRamDat0 != bus.PkeRamDat1)
        bus.CollErr <= 1'b1;
    end

  always_ff @(posedge Clk or negedge Resetn)
    if (!Resetn) begin
      state <= IDLE;
      waitCnt <= '0;
      hWr <= 1'b0;
      hAddr <= '0;
      hWdat <= '0;
      bus.HostAck <= 1'b0;
      bus.HostErr <= 1'b0;
      bus.HostRdat <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.HostAck <= 1'b0;
          bus.HostErr <= 1'b0;
          if (bus.HostReq) begin
            hWr <= bus.HostWr;
            hAddr <= bus.HostAddr;
            hWdat <= bus.HostWdat;
            waitCnt <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (hostGo) begin
            if (!hWr) bus.HostRdat <= hostHalf;
            bus.HostAck <= 1'b1;
            state <= RESP;
          end else begin
            waitCnt <= waitCnt + 1'b1;
            // Counter reaches HOST_TMO-1 on this busy cycle: give up
            if (waitCnt == CW'(HOST_TMO - 2)) begin
              bus.HostRdat <= '0;
              bus.HostAck <= 1'b1;
              bus.HostErr <= 1'b1;
              state <= RESP;
            end
          end
        end
        RESP: begin
          bus.HostAck <= 1'b0;
          bus.HostErr <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end

`ifdef PKE_RAM_PARITY_EN
  logic [1:0] parMem [DEPTH];

  function automatic logic [1:0] parOf(input logic [63:0] d);
    return {^d[63:32], ^d[31:0]};
  endfunction

  always_ff @(posedge Clk) begin
    if (wr1) parMem[bus.PkeRamAddr1] <= parOf(bus.PkeRamDat1);
    if (wr0) parMem[bus.PkeRamAddr0] <= parOf(bus.PkeRamDat0);
    if (hostGo && hWr && hostOk) parMem[hWord][hAddr[0]] <= ^hWdat;
  end

  always_ff @(posedge Clk or negedge Resetn)
    if (!Resetn) bus.ParityErr <= 1'b0;
    else if ((rd0 && parOf(mem[bus.PkeRamAddr0]) != parMem[bus.PkeRamAddr0]) ||
             (rd1 && parOf(mem[bus.PkeRamAddr1]) != parMem[bus.PkeRamAddr1]) ||
             (hostGo && !hWr && hostOk && (^hostHalf) != parMem[hWord][hAddr[0]]))
      bus.ParityErr <= 1'b1;
`else
  assign bus.ParityErr = 1'b0;
`endif
endmodule

// File: tb/tb_pke_ram_core.sv
// tb_pke_ram_core: table-driven engine vectors plus host/collision/timeout sequences with scoreboards.
module tb_pke_ram_core;
  logic Clk = 1'b0;
  logic Resetn = 1'b0;
  int total = 0;
  int bad = 0;
  logic [63:0] sb0[$], sb1[$];
  logic [31:0] sbH[$];

  pke_ram_core_if bus();
  pke_ram_core #(.DEPTH(512), .HOST_TMO(64)) dut (.Clk(Clk), .Resetn(Resetn), .bus(bus));

  always #5 Clk = ~Clk;

  typedef struct {
    logic rd0, wr0;
    logic [8:0] a0;
    logic [63:0] d0;
    logic rd1, wr1;
    logic [8:0] a1;
    logic [63:0] d1;
    logic chk0;
    logic [63:0] e0;
    logic chk1;
    logic [63:0] e1;
  } vec_t;
  vec_t vecs[11];

  function automatic vec_t mkVec(input logic rd0, wr0, input logic [8:0] a0, input logic [63:0] d0,
                                 input logic rd1, wr1, input logic [8:0] a1, input logic [63:0] d1,
                                 input logic chk0, input logic [63:0] e0, input logic chk1, input logic [63:0] e1);
    return '{rd0, wr0, a0, d0, rd1, wr1, a1, d1, chk0, e0, chk1, e1};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idleIn();
    bus.PkeRamRd0 = 0; bus.PkeRamWr0 = 0; bus.PkeRamAddr0 = '0; bus.PkeRamDat0 = '0;
    bus.PkeRamRd1 = 0; bus.PkeRamWr1 = 0; bus.PkeRamAddr1 = '0; bus.PkeRamDat1 = '0;
    bus.HostReq = 0; bus.HostWr = 0; bus.HostAddr = '0; bus.HostWdat = '0;
  endtask

  task automatic doReset();
    Resetn = 1'b0;
    idleIn();
    repeat (2) @(posedge Clk);
    #1 Resetn = 1'b1;
  endtask

  task automatic engStep(input string nm, input vec_t v);
    bus.PkeRamRd0 = v.rd0; bus.PkeRamWr0 = v.wr0; bus.PkeRamAddr0 = v.a0; bus.PkeRamDat0 = v.d0;
    bus.PkeRamRd1 = v.rd1; bus.PkeRamWr1 = v.wr1; bus.PkeRamAddr1 = v.a1; bus.PkeRamDat1 = v.d1;
    if (v.chk0) sb0.push_back(v.e0);
    if (v.chk1) sb1.push_back(v.e1);
    @(posedge Clk); #1;
    bus.PkeRamRd0 = 0; bus.PkeRamWr0 = 0; bus.PkeRamRd1 = 0; bus.PkeRamWr1 = 0;
    if (v.chk0) check({nm, "_q0"}, bus.PkeRamQ0, sb0.pop_front());
    if (v.chk1) check({nm, "_q1"}, bus.PkeRamQ1, sb1.pop_front());
  endtask

  task automatic wrWord(input logic [8:0] a, input logic [63:0] d);
    engStep("wr", mkVec(0, 1, a, d, 0, 0, '0, '0, 0, '0, 0, '0));
  endtask

  task automatic rdWord(input string nm, input logic [8:0] a, input logic [63:0] e);
    engStep(nm, mkVec(0, 0, '0, '0, 1, 0, a, '0, 0, '0, 1, e));
  endtask

  task automatic hostOp(input logic wr, input logic [9:0] addr, input logic [31:0] wd,
                        output int lat, output logic err, output logic [31:0] rd);
    @(posedge Clk); #1;
    bus.HostReq = 1; bus.HostWr = wr; bus.HostAddr = addr; bus.HostWdat = wd;
    lat = 0;
    while (bus.HostAck !== 1'b1 && lat < 200) begin
      @(posedge Clk); #1;
      lat++;
    end
    if (bus.HostAck !== 1'b1) begin
      total++; bad++;
      $display("FAIL host_ack_wait: got no ack want ack within 200 cycles");
    end
    err = bus.HostErr;
    rd = bus.HostRdat;
    bus.HostReq = 0;
    @(posedge Clk); #1;
    check("ack_pulse", 64'(bus.HostAck), 64'd0);
  endtask

  // Port 0 is held busy (reads of a written word) from the cycle HostReq rises
  task automatic hostChk(input string nm, input logic wr, input logic [9:0] addr, input logic [31:0] wd,
                         input int busy, input int expLat, input logic expErr, input logic [31:0] expRd);
    int lat;
    logic err;
    logic [31:0] rd;
    if (!wr) sbH.push_back(expRd);
    fork
      if (busy > 0) begin
        @(posedge Clk); #1;
        bus.PkeRamRd0 = 1; bus.PkeRamAddr0 = 9'h024;
        repeat (busy) @(posedge Clk);
        #1 bus.PkeRamRd0 = 0;
      end
      hostOp(wr, addr, wd, lat, err, rd);
    join
    check({nm, "_lat"}, 64'(lat), 64'(expLat));
    check({nm, "_err"}, 64'(err), 64'(expErr));
    if (!wr) check({nm, "_rdat"}, 64'(rd), 64'(sbH.pop_front()));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic err;
    logic [31:0] rd;
    vecs[0]  = mkVec(0, 1, 9'h024, 64'h0123456789ABCDEF, 0, 0, 9'h000, '0, 0, '0, 0, '0);
    vecs[1]  = mkVec(0, 0, 9'h000, '0, 1, 0, 9'h024, '0, 0, '0, 1, 64'h0123456789ABCDEF);
    vecs[2]  = mkVec(1, 0, 9'h024, '0, 0, 1, 9'h030, 64'hCAFEF00DCAFEF00D, 1, 64'h0123456789ABCDEF, 0, '0);
    vecs[3]  = mkVec(1, 1, 9'h030, 64'h1111111111111111, 0, 0, 9'h000, '0, 1, 64'hCAFEF00DCAFEF00D, 0, '0);
    vecs[4]  = mkVec(1, 0, 9'h030, '0, 0, 1, 9'h030, 64'h2222222222222222, 1, 64'h1111111111111111, 0, '0);
    vecs[5]  = mkVec(1, 0, 9'h030, '0, 1, 0, 9'h024, '0, 1, 64'h2222222222222222, 1, 64'h0123456789ABCDEF);
    vecs[6]  = mkVec(0, 1, 9'h1FF, 64'hFFFF0000FFFF0000, 0, 1, 9'h000, 64'h00000000DEADD00D, 0, '0, 0, '0);
    vecs[7]  = mkVec(1, 0, 9'h000, '0, 1, 0, 9'h1FF, '0, 1, 64'h00000000DEADD00D, 1, 64'hFFFF0000FFFF0000);
    vecs[8]  = mkVec(0, 0, 9'h000, '0, 0, 0, 9'h000, '0, 1, 64'h00000000DEADD00D, 1, 64'hFFFF0000FFFF0000);
    vecs[9]  = mkVec(0, 0, 9'h000, '0, 1, 1, 9'h030, 64'h3333333333333333, 1, 64'h00000000DEADD00D, 1, 64'h2222222222222222);
    vecs[10] = mkVec(1, 0, 9'h030, '0, 0, 0, 9'h000, '0, 1, 64'h3333333333333333, 0, '0);

    idleIn();
    doReset();
    check("rst_q0", bus.PkeRamQ0, 64'd0);
    check("rst_q1", bus.PkeRamQ1, 64'd0);
    check("rst_hrdat", 64'(bus.HostRdat), 64'd0);
    check("rst_hack", 64'(bus.HostAck), 64'd0);
    check("rst_herr", 64'(bus.HostErr), 64'd0);
    check("rst_coll", 64'(bus.CollErr), 64'd0);
    check("rst_par", 64'(bus.ParityErr), 64'd0);

    for (int i = 0; i < 11; i++) engStep($sformatf("vec%0d", i), vecs[i]);
    check("coll_none", 64'(bus.CollErr), 64'd0);

    engStep("coll", mkVec(0, 1, 9'h100, {16{4'hA}}, 0, 1, 9'h100, {16{4'h5}}, 0, '0, 0, '0));
    check("coll_set", 64'(bus.CollErr), 64'd1);
    rdWord("coll_win", 9'h100, {16{4'hA}});
    repeat (3) @(posedge Clk);
    #1 check("coll_sticky", 64'(bus.CollErr), 64'd1);
    doReset();
    check("coll_rst", 64'(bus.CollErr), 64'd0);
    engStep("coll_eq", mkVec(0, 1, 9'h100, 64'h5A5A5A5A5A5A5A5A, 0, 1, 9'h100, 64'h5A5A5A5A5A5A5A5A, 0, '0, 0, '0));
    check("coll_eq", 64'(bus.CollErr), 64'd0);
    rdWord("coll_eq", 9'h100, 64'h5A5A5A5A5A5A5A5A);

    wrWord(9'h024, 64'h0123456789ABCDEF);
    wrWord(9'h02D, 64'h1111111122222222);
    hostChk("hwr", 1, 10'h05B, 32'hDEADBEEF, 0, 2, 0, '0);
    rdWord("hwr_word", 9'h02D, 64'hDEADBEEF22222222);
    hostChk("hrd_hi", 0, 10'h05B, '0, 0, 2, 0, 32'hDEADBEEF);
    hostChk("hrd_lo", 0, 10'h05A, '0, 0, 2, 0, 32'h22222222);
    hostChk("busy10", 0, 10'h05A, '0, 10, 11, 0, 32'h22222222);
    hostChk("busy63", 0, 10'h05B, '0, 63, 64, 0, 32'hDEADBEEF);
    hostChk("tmo_rd", 0, 10'h05B, '0, 80, 64, 1, 32'h0);
    hostChk("tmo_wr", 1, 10'h05A, 32'h99999999, 80, 64, 1, '0);
    rdWord("tmo_word", 9'h02D, 64'hDEADBEEF22222222);

    wrWord(9'h040, 64'h0);
    fork
      begin
        repeat (2) @(posedge Clk);
        #1;
        bus.PkeRamWr1 = 1; bus.PkeRamAddr1 = 9'h040; bus.PkeRamDat1 = 64'hAAAAAAAABBBBBBBB;
        @(posedge Clk);
        #1 bus.PkeRamWr1 = 0;
      end
      hostOp(1, 10'h080, 32'h12345678, lat, err, rd);
    join
    check("hp1_lat", 64'(lat), 64'd2);
    rdWord("hp1_word", 9'h040, 64'hAAAAAAAA12345678);
    check("hp1_coll", 64'(bus.CollErr), 64'd0);

    bus.PkeRamRd0 = 1; bus.PkeRamAddr0 = 9'h024;
    bus.HostReq = 1; bus.HostWr = 1; bus.HostAddr = 10'h05A; bus.HostWdat = 32'h77777777;
    repeat (5) @(posedge Clk);
    #1 doReset();
    check("midrst_ack", 64'(bus.HostAck), 64'd0);
    rdWord("midrst_word", 9'h02D, 64'hDEADBEEF22222222);
    hostChk("midrst_next", 0, 10'h05A, '0, 0, 2, 0, 32'h22222222);

`ifdef PKE_RAM_PARITY_EN
    wrWord(9'h180, 64'h0F0F0F0F0F0F0F0F);
    rdWord("par_ok", 9'h180, 64'h0F0F0F0F0F0F0F0F);
    check("par_ok", 64'(bus.ParityErr), 64'd0);
    dut.mem[9'h180] = dut.mem[9'h180] ^ 64'h1;
    rdWord("par_bad", 9'h180, 64'h0F0F0F0F0F0F0F0E);
    check("par_set", 64'(bus.ParityErr), 64'd1);
    repeat (3) @(posedge Clk);
    #1 check("par_sticky", 64'(bus.ParityErr), 64'd1);
    doReset();
    check("par_rst", 64'(bus.ParityErr), 64'd0);
`else
    check("par_off", 64'(bus.ParityErr), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pke_ram_core.md
Name: pke_ram_core

Overview:
Responder end of the PKE engine RAM interface: the dual-port 64-bit working store that services PkeRam port 0/1 requests from the RAM mux. It adds a 32-bit host side-port, used by the CPU to load operands and read results, that borrows port 0 only when the engine leaves it idle. It also provides read-data registers, write-collision detection and host starvation reporting.

Parameters:
DEPTH, 512, number of 64-bit words; address width is 9 bits.
HOST_TMO, 64, max cycles a pending host request waits for port 0 before erroring out.

Ports:
Clk  in  1  clock
Resetn  in  1  asynchronous active-low reset
PkeRamRd0  in  1  engine port 0 read strobe
PkeRamWr0  in  1  engine port 0 write strobe
PkeRamAddr0  in  9  engine port 0 word address
PkeRamDat0  in  64  engine port 0 write data
PkeRamRd1  in  1  engine port 1 read strobe
PkeRamWr1  in  1  engine port 1 write strobe
PkeRamAddr1  in  9  engine port 1 word address
PkeRamDat1  in  64  engine port 1 write data
PkeRamQ0  out  64  port 0 read data
PkeRamQ1  out  64  port 1 read data
HostReq  in  1  host access request, held until HostAck
HostWr  in  1  1 = write, 0 = read; qualified by HostReq
HostAddr  in  10  [9:1] word address, [0] half select (0 = bits 31:0)
HostWdat  in  32  host write data
HostRdat  out  32  host read data, valid with HostAck
HostAck  out  1  one-cycle completion pulse
HostErr  out  1  one-cycle pulse with HostAck when the request timed out
CollErr  out  1  sticky: both engine ports wrote the same address in one cycle
ParityErr  out  1  sticky parity error (optional feature)

Behaviour:
- Reset values: PkeRamQ0, PkeRamQ1 and HostRdat = 0; HostAck, HostErr, CollErr and ParityErr = 0; FSM in IDLE; wait counter = 0. Array contents are not reset.
- Engine reads: 1-cycle latency. PkeRamQn is registered on the cycle after PkeRamRdn and holds until the next read on that port.
- Engine writes: committed at the clock edge.
- Same-port read and write on the same address in one cycle returns the old data (read-first).
- Cross-port read of an address being written in the same cycle also returns the old data.
- Both ports writing the same address in one cycle: port 0 data wins. CollErr sets only if PkeRamDat0 != PkeRamDat1. Equal data is legal; the mux mirrors port 0 onto port 1 in RSA and point modes.
- Writes with address >= DEPTH are dropped; reads with address >= DEPTH return 0. No error is raised in either case.
- CollErr clears only on reset.
- Host FSM:
  - IDLE: on HostReq, latch HostWr, HostAddr and HostWdat, clear the counter, go to WAIT.
  - WAIT: if PkeRamRd0 = 0 and PkeRamWr0 = 0 this cycle, perform the access on port 0 and go to RESP. Otherwise increment the counter; when it reaches HOST_TMO-1, go to RESP flagged as error with no access.
  - RESP: pulse HostAck. HostRdat holds the selected half on a read (0 on error). HostErr = error flag. Go to IDLE. A new request is sampled no earlier than the cycle after HostAck.
- Host write updates only the addressed 32-bit half; the other half is unchanged.
- Host read latency is at least 2 cycles from HostReq to HostAck.
- An engine port 0 access arriving in the same cycle the host is granted cannot occur, because the grant is conditioned on the idle cycle. Engine port 1 stays fully concurrent with host accesses. A host write colliding with a port 1 write to the same word: the host half wins and port 1's other half is written; CollErr is not set.
- Reset mid-operation: FSM returns to IDLE, and any host access not yet committed is lost.

Optional Feature:
Macro PKE_RAM_PARITY_EN.
- Defined: one even-parity bit is stored per 32-bit half, written on every engine or host write. It is checked on every engine or host read of that half.
- On mismatch, ParityErr sets (sticky until reset) and the data is still returned unmodified.
- Undefined: no parity storage; ParityErr is tied to 0.

Test Plan:
- Write Addr0=0x024 Dat0=0x0123456789ABCDEF, then read Rd1 Addr1=0x024 next cycle -> PkeRamQ1=0x0123456789ABCDEF one cycle after the read strobe.
- Wr0 and Wr1 both to 0x100, Dat0=0xAA..AA, Dat1=0x55..55 -> word 0x100 = 0xAA..AA, CollErr=1. Repeat with equal data after reset -> CollErr stays 0.
- Host write HostAddr=0x05B (word 0x02D, upper half) data 0xDEADBEEF over a word preloaded with 0x1111111122222222, port 0 idle -> HostAck at cycle 2, word = 0xDEADBEEF22222222.
- Engine holds Rd0 high for 10 cycles while HostReq is pending -> no HostAck during the busy cycles; access completes on the first idle cycle.
- Port 0 busy continuously for 64 cycles with a pending host read -> HostAck with HostErr=1, HostRdat=0, array unchanged.
- With PKE_RAM_PARITY_EN, force-flip one stored bit via backdoor at 0x180 and read it -> ParityErr=1 and stays 1 until Resetn low.
